// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life run controller and grid engine.
//   GRID_W      : grid edge length in cells
//   GRID_N      : cells per grid, which is also the serial frame length
//   ctl_state_t : run-controller sequencing states
package gol_pkg;

    localparam int GRID_W = 6;
    localparam int GRID_N = GRID_W * GRID_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STEP  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } ctl_state_t;

endpackage

// File: rtl/gol_cell_counter.sv
// Modulo-N cell position counter shared by the seed load and result drain.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : return the count to zero (wins over inc)
//   inc          : advance one cell, wrapping from N-1 back to zero
//   last         : count is at cell N-1 (combinational)
module gol_cell_counter
    import gol_pkg::*;
#(
    parameter int N = GRID_N
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    logic [CNT_W-1:0] count_r;

    // Cell position register with wrap at the final cell of the frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            if (last) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == LAST_CNT);

endmodule

// File: rtl/gol_run_controller.sv
// Run controller for the Game-of-Life grid engine. Loads a serial seed from
// the host, commands the programmed number of generations, then streams the
// result back while rotating the engine so its contents are preserved.
//   clock, reset            : system clock, synchronous active-high reset
//   start, abort, cfg_gens  : job control (start sampled in IDLE only)
//   in_bit/in_valid/in_ready    : seed stream, cell 0 first
//   out_bit/out_valid/out_ready : result stream, same order as seed
//   eng_shift_en/eng_shift_in/eng_cell_out : engine serial chain
//   eng_step, eng_busy      : engine generation command / handshake
//   busy, done, gen_count   : job status
module gol_run_controller
    import gol_pkg::*;
#(
    parameter int N     = GRID_N,
    parameter int GEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [GEN_W-1:0] cfg_gens,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eng_shift_en,
    output logic             eng_shift_in,
    input  logic             eng_cell_out,
    output logic             eng_step,
    input  logic             eng_busy,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count
);

    ctl_state_t       state_r;
    ctl_state_t       state_next_s;
    logic [GEN_W-1:0] gens_q_r;
    logic [GEN_W-1:0] gen_count_r;
    logic             wait_first_r;

    logic             cell_last_s;
    logic             cnt_clear_s;
    logic             load_accept_s;
    logic             drain_accept_s;
    logic             job_start_s;
    logic             gen_done_s;
    logic [GEN_W:0]   gen_next_s;
    logic             more_gens_s;

    gol_cell_counter #(
        .N (N)
    ) u_cell_counter (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear_s),
        .inc   (eng_shift_en),
        .last  (cell_last_s)
    );

    // Handshake decode, engine chain control and status outputs.
    always_comb begin
        load_accept_s  = (state_r == LOAD) && in_valid;
        drain_accept_s = (state_r == DRAIN) && out_ready;
        job_start_s    = (state_r == IDLE) && start && !abort;
        // The engine raises busy one cycle after step, so the first WAIT
        // cycle must not read eng_busy as "finished".
        gen_done_s     = (state_r == WAIT) && !wait_first_r && !eng_busy && !abort;
        gen_next_s     = {1'b0, gen_count_r} + {{GEN_W{1'b0}}, 1'b1};
        more_gens_s    = (gen_next_s < {1'b0, gens_q_r});
        // The counter rests at zero whenever no job is running.
        cnt_clear_s    = (state_r == IDLE) || abort;

        in_ready     = (state_r == LOAD);
        out_valid    = (state_r == DRAIN);
        out_bit      = (state_r == DRAIN) ? eng_cell_out : 1'b0;
        eng_shift_en = load_accept_s || drain_accept_s;
        if (load_accept_s) begin
            eng_shift_in = in_bit;
        end else if (drain_accept_s) begin
            // Rotate the result back into the chain to keep the engine intact.
            eng_shift_in = eng_cell_out;
        end else begin
            eng_shift_in = 1'b0;
        end
        eng_step     = (state_r == STEP);
        busy         = (state_r != IDLE);
        done         = drain_accept_s && cell_last_s && !abort;
        gen_count    = gen_count_r;
    end

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (in_valid && cell_last_s) begin
                    state_next_s = (gens_q_r != {GEN_W{1'b0}}) ? STEP : DRAIN;
                end else begin
                    state_next_s = LOAD;
                end
            end
            STEP: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (!wait_first_r && !eng_busy) begin
                    state_next_s = more_gens_s ? STEP : DRAIN;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DRAIN: begin
                if (out_ready && cell_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (abort) begin
            state_next_s = IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Marks the first WAIT cycle, the one right after the step pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_first_r <= 1'b0;
        end else begin
            wait_first_r <= (state_r == STEP) && !abort;
        end
    end

    // Generation target, captured only when a job is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            gens_q_r <= {GEN_W{1'b0}};
        end else if (job_start_s) begin
            gens_q_r <= cfg_gens;
        end else begin
            gens_q_r <= gens_q_r;
        end
    end

    // Completed-generation count; held after abort and in IDLE, saturates at target.
    always_ff @(posedge clock) begin
        if (reset) begin
            gen_count_r <= {GEN_W{1'b0}};
        end else if (job_start_s) begin
            gen_count_r <= {GEN_W{1'b0}};
        end else if (gen_done_s && (gen_count_r < gens_q_r)) begin
            gen_count_r <= gen_next_s[GEN_W-1:0];
        end else begin
            gen_count_r <= gen_count_r;
        end
    end

endmodule

// File: tb/tb_gol_run_controller.sv
// Directed testbench for gol_run_controller with a behavioural grid engine.
module tb_gol_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_gens = 8'd0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_bit;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        eng_shift_en;
    logic        eng_shift_in;
    logic        eng_cell_out;
    logic        eng_step;
    logic        eng_busy;
    logic        busy;
    logic        done;
    logic [7:0]  gen_count;

    int checks = 0;
    int failures = 0;

    gol_run_controller dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cfg_gens     (cfg_gens),
        .in_bit       (in_bit),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_bit      (out_bit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .eng_shift_en (eng_shift_en),
        .eng_shift_in (eng_shift_in),
        .eng_cell_out (eng_cell_out),
        .eng_step     (eng_step),
        .eng_busy     (eng_busy),
        .busy         (busy),
        .done         (done),
        .gen_count    (gen_count)
    );

    always #5 clock = ~clock;

    // Behavioural engine: chain shifts toward bit 0, dead cells beyond the border.
    function automatic logic [35:0] life(input logic [35:0] g);
        logic [35:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 6 &&
                            (c + dc) >= 0 && (c + dc) < 6) begin
                            cnt = cnt + int'(g[(r + dr) * 6 + (c + dc)]);
                        end
                    end
                end
                n[r * 6 + c] = g[r * 6 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    logic [35:0] chain = 36'd0;
    int          bcnt = 0;
    int          busy_len = 1;

    always @(posedge clock) begin
        if (eng_step) begin
            chain <= life(chain);
        end else if (eng_shift_en) begin
            chain <= {eng_shift_in, chain[35:1]};
        end
        if (eng_step) begin
            bcnt <= busy_len;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
    end

    assign eng_cell_out = chain[0];
    assign eng_busy     = (bcnt != 0);

    // Event monitor.
    int cyc = 0;
    int n_shift = 0;
    int n_step = 0;
    int n_done = 0;
    int step_last = 0;
    int step_prev = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (eng_shift_en) n_shift <= n_shift + 1;
        if (done) n_done <= n_done + 1;
        if (eng_step) begin
            n_step    <= n_step + 1;
            step_prev <= step_last;
            step_last <= cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issues start at a negedge; returns at the next negedge with state LOAD.
    task automatic start_job(input logic [7:0] g);
        @(negedge clock);
        cfg_gens = g;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        cfg_gens = 8'hFF;
    endtask

    task automatic load_seed(input logic [35:0] seed, input bit gaps);
        int  i;
        int  k;
        bit  acc;
        i = 0;
        k = 0;
        while (i < 36 && k < 300) begin
            in_valid = !(gaps && (k % 3 == 1));
            in_bit   = seed[i];
            #1;
            acc = in_valid && in_ready;
            if (acc) begin
                chk("load_shift_en", eng_shift_en, 1);
                chk("load_shift_in", eng_shift_in, in_bit);
            end else if (!in_valid) begin
                chk("gap_no_shift", eng_shift_en, 0);
            end
            @(negedge clock);
            if (acc) i++;
            k++;
        end
        in_valid = 1'b0;
        chk("load_count", i, 36);
    endtask

    task automatic drain(input bit stall, output logic [35:0] res);
        int k;
        int j;
        bit prev_acc;
        logic prev_bit;
        res = '0;
        k = 0;
        #1;
        while (!out_valid && k < 3000) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("drain_reached", out_valid, 1);
        j = 0;
        k = 0;
        prev_acc = 1'b1;
        prev_bit = 1'b0;
        while (j < 36 && k < 400) begin
            out_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            #1;
            chk("out_valid", out_valid, 1);
            chk("done_pulse", done, (out_ready && j == 35));
            chk("drain_shift_en", eng_shift_en, out_ready);
            if (k > 0 && !prev_acc) chk("stall_stable", out_bit, prev_bit);
            if (out_ready) res[j] = out_bit;
            prev_bit = out_bit;
            prev_acc = out_ready;
            @(negedge clock);
            if (prev_acc) j++;
            k++;
        end
        out_ready = 1'b0;
        chk("drain_count", j, 36);
    endtask

    typedef struct {
        logic [7:0]  gens;
        logic [35:0] seed;
        logic [35:0] exp_out;
        logic [7:0]  exp_gc;
        int          exp_steps;
        int          blen;
        bit          gaps;
        bit          stall;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [35:0] res;
        int s_shift;
        int s_step;
        int s_done;
        int k;

        vecs[0] = '{8'd0, 36'h0_0000_0F0F, 36'h0_0000_0F0F, 8'd0, 0, 1, 1'b0, 1'b0};
        vecs[1] = '{8'd1, 36'h0_0010_4100, 36'h0_0000_E000, 8'd1, 1, 3, 1'b0, 1'b0};
        vecs[2] = '{8'd2, 36'h0_0010_4100, 36'h0_0010_4100, 8'd2, 2, 36, 1'b0, 1'b0};
        vecs[3] = '{8'd1, 36'h0_0010_4100, 36'h0_0000_E000, 8'd1, 1, 2, 1'b1, 1'b1};
        vecs[4] = '{8'd3, 36'h0_0000_00C3, 36'h0_0000_00C3, 8'd3, 3, 1, 1'b1, 1'b0};

        // Reset and idle.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        chk("reset_outputs", {in_ready, out_valid, out_bit, eng_shift_en, eng_shift_in,
                              eng_step, busy, done, gen_count}, 0);

        // start together with abort is dropped.
        @(negedge clock);
        start    = 1'b1;
        abort    = 1'b1;
        cfg_gens = 8'd5;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("start_abort_idle", {busy, in_ready}, 0);

        // Table-driven jobs.
        for (int v = 0; v < 5; v++) begin
            busy_len = vecs[v].blen;
            s_shift  = n_shift;
            s_step   = n_step;
            s_done   = n_done;
            start_job(vecs[v].gens);
            chk("busy_in_load", busy, 1);
            load_seed(vecs[v].seed, vecs[v].gaps);
            chk("load_shifts", n_shift - s_shift, 36);
            drain(vecs[v].stall, res);
            #1;
            chk("result", res, vecs[v].exp_out);
            chk("gen_count", gen_count, vecs[v].exp_gc);
            chk("step_count", n_step - s_step, vecs[v].exp_steps);
            chk("done_count", n_done - s_done, 1);
            chk("total_shifts", n_shift - s_shift, 72);
            chk("idle_after_job", busy, 0);
            if (vecs[v].blen == 36) begin
                chk("step_spacing", (step_last - step_prev) >= 37, 1);
            end
        end

        // Abort in WAIT during generation 4 of 8 (three completed).
        busy_len = 4;
        s_step   = n_step;
        s_done   = n_done;
        start_job(8'd8);
        load_seed(36'h0_0010_4100, 1'b0);
        k = 0;
        while (k < 2000) begin
            #1;
            if ((n_step - s_step) == 4 && busy && !eng_step && !in_ready && !out_valid) break;
            @(negedge clock);
            k++;
        end
        chk("abort_steps_seen", n_step - s_step, 4);
        chk("abort_gc_before", gen_count, 3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        #1;
        chk("abort_idle", busy, 0);
        chk("abort_gc_held", gen_count, 3);
        chk("abort_no_done", n_done - s_done, 0);

        // A fresh job after abort completes normally.
        busy_len = 2;
        s_done   = n_done;
        start_job(8'd1);
        load_seed(36'h0_0000_00C3, 1'b0);
        drain(1'b0, res);
        #1;
        chk("post_abort_result", res, 36'h0_0000_00C3);
        chk("post_abort_gc", gen_count, 1);
        chk("post_abort_done", n_done - s_done, 1);

        // Reset mid-load clears everything.
        start_job(8'd2);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_reset_outputs", {in_ready, out_valid, eng_shift_en, eng_step, busy, done,
                                  gen_count}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
